// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier built around a ripple-carry adder.
// Optional build macro: SHIFT_ADD_ZERO_BYPASS_EN (zero operands finish in one cycle).

package soc_pkg;
  parameter int DATA_WIDTH = 8;
  typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

module ripplecarry_adder #(
  parameter int WIDTH = soc_pkg::DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  logic [WIDTH:0] c;

  assign c[0] = carryIn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (a[i] & c[i])
                    | (b[i] & c[i]);
  end

  assign carryOut = c[WIDTH];

endmodule

module shift_add_multiplier #(
  parameter int DATA_WIDTH = soc_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] mcand;
  logic [DW-1:0] acc_hi;
  logic [DW-1:0] acc_lo;
  logic [CW-1:0] cnt;

  logic [DW-1:0]   add_b;
  logic [DW-1:0]   sum;
  logic            carry;
  logic [2*DW-1:0] nxt;

  // Partial-product add: multiplicand gated by the current multiplier bit.
  assign add_b = acc_lo[0] ? mcand : '0;

  ripplecarry_adder #(
    .WIDTH (DW)
  ) u_add (
    .a        (acc_hi),
    .b        (add_b),
    .carryIn  (1'b0),
    .sum      (sum),
    .carryOut (carry)
  );

  // Shift {carry, sum, acc_lo} right by one; the carry becomes the new MSB.
  assign nxt = {carry, sum, acc_lo[DW-1:1]};

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
            if ((a == '0) || (b == '0)) begin
              product <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              mcand  <= a;
              acc_hi <= '0;
              acc_lo <= b;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end
`else
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`endif
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= nxt;
          cnt              <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random bench for shift_add_multiplier.
// Reference: product = a*b, latency from the operand rules.
module tb_shift_add_multiplier;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          busy;
  logic          done;
  logic [2*DW-1:0] product;

  int total = 0;
  int bad   = 0;
  bit fatal_on_error = 1'b0;

  shift_add_multiplier #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [DW-1:0] x,
                                 input logic [DW-1:0] y);
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
    if (x == 0 || y == 0) return 1;
`endif
    return DW + 1;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_mult(input logic [DW-1:0] x,
                         input logic [DW-1:0] y,
                         input bit scramble,
                         output int lat,
                         output int bcnt);
    a     = x;
    b     = y;
    start = 1'b1;
    lat   = -1;
    bcnt  = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        if (scramble) begin
          a = 8'($urandom);
          b = 8'($urandom);
        end
      end
      bcnt += int'(busy);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic mult_chk(input string tag,
                          input logic [DW-1:0] x,
                          input logic [DW-1:0] y,
                          input bit scramble);
    int lat;
    int bc;
    do_mult(x, y, scramble, lat, bc);
    check({tag, "_lat"}, lat, exp_lat(x, y));
    check({tag, "_prod"}, product, 32'(int'(x) * int'(y)));
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int lat, bc, nd, d1, d2, bc2;
    logic [2*DW-1:0] p1, p2;
    logic [DW-1:0] rx, ry;
    int bad0;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 13*11 with busy length and product hold.
    do_mult(8'd13, 8'd11, 1'b0, lat, bc);
    check("basic_lat", lat, DW + 1);
    check("basic_busy", bc, DW);
    check("basic_prod", product, 16'h008F);
    repeat (5) @(negedge clk);
    check("basic_hold", product, 16'h008F);
    check("basic_idle", done, 0);

    // Carry-out path.
    mult_chk("c255x255", 8'd255, 8'd255, 1'b0);
    mult_chk("c255x1", 8'd255, 8'd1, 1'b0);
    mult_chk("c128x2", 8'd128, 8'd2, 1'b0);

    // start pulses during RUN and DONE are ignored.
    a = 8'd3; b = 8'd4; start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin a = 8'd9; b = 8'd9; end
      if (i == 3) start = 1'b1;
      if (done) begin
        nd++;
        p1 = product;
        if (nd == 1) start = 1'b1;
      end
      if (i > 12) check("ign_busy", busy, 0);
    end
    check("ign_ndone", nd, 1);
    check("ign_prod", p1, 12);

    // Reset on the 4th RUN edge aborts the operation.
    a = 8'd200; b = 8'd200; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_prod", product, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("mrst_nodone", nd, 0);
    mult_chk("after_rst", 8'd2, 8'd3, 1'b0);

    // Back-to-back with start held high, second operand zero.
    a = 8'd7; b = 8'd6; start = 1'b1;
    d1 = -1; d2 = -1; bc2 = 0;
    p1 = '0; p2 = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin a = 8'd0; b = 8'd77; end
      if (d1 >= 0) bc2 += int'(busy);
      if (done) begin
        if (d1 < 0) begin
          d1 = i;
          p1 = product;
        end else begin
          d2 = i;
          p2 = product;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_d1", d1, DW + 1);
    check("b2b_p1", p1, 42);
    check("b2b_space", d2 - d1, 1 + exp_lat(8'd0, 8'd77));
    check("b2b_p2", p2, 0);
    check("b2b_busy2", bc2, exp_lat(8'd0, 8'd77) - 1);
    @(negedge clk);
    check("b2b_pulse", done, 0);
    mult_chk("zero_b", 8'd91, 8'd0, 1'b0);

    // Random operands, inputs scrambled after acceptance.
    for (int n = 0; n < 200; n++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      if (n == 0) rx = 8'd0;
      if (n == 1) ry = 8'd0;
      bad0 = bad;
      mult_chk("rand", rx, ry, 1'b1);
      if (fatal_on_error && bad != bad0)
        $fatal(1, "stopping at random vector %0d", n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
